// File: rtl/slot_scorer.sv
// Scoring engine for the one-arm-bandit game: debits a bet per accepted turn,
// classifies the stopped reels as jackpot, pair or loss, and credits a saturating payout.
module slot_scorer #(
    parameter int N_REELS     = 3,
    parameter int SYM_W       = 4,
    parameter int CREDIT_W    = 8,
    parameter int INIT_CREDIT = 10,
    parameter int BET         = 1,
    parameter int JACKPOT_PAY = 10,
    parameter int PAIR_PAY    = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       turn_p,
    input  logic                       clr_p,
    input  logic                       reel_valid,
    input  logic [N_REELS*SYM_W-1:0]   reel_bus,
    output logic [CREDIT_W-1:0]        credit,
    output logic [CREDIT_W-1:0]        win,
    output logic                       pass_p,
    output logic                       jackpot_p,
    output logic                       busy,
    output logic                       game_over
);

    localparam int BUS_W = N_REELS * SYM_W;
    localparam logic [CREDIT_W-1:0] INIT_C = CREDIT_W'(INIT_CREDIT);
    localparam logic [CREDIT_W-1:0] BET_C  = CREDIT_W'(BET);
    localparam logic [CREDIT_W-1:0] JP_C   = CREDIT_W'(JACKPOT_PAY);
    localparam logic [CREDIT_W-1:0] PAIR_C = CREDIT_W'(PAIR_PAY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SPIN,
        S_EVAL
    } state_t;

    state_t                state_q,   state_d;
    logic [CREDIT_W-1:0]   credit_q,  credit_d;
    logic [CREDIT_W-1:0]   win_q,     win_d;
    logic                  pass_q,    pass_d;
    logic                  jackpot_q, jackpot_d;
    logic [BUS_W-1:0]      reels_q,   reels_d;

    logic                  all_eq;
    logic                  any_pair;
    logic [CREDIT_W-1:0]   pay;
    logic [CREDIT_W:0]     sum_w;
    logic [CREDIT_W-1:0]   credit_sat;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        all_eq   = 1'b1;
        any_pair = 1'b0;
        for (int i = 1; i < N_REELS; i++) begin
            if (reels_q[i*SYM_W +: SYM_W] != reels_q[0 +: SYM_W]) all_eq = 1'b0;
        end
        for (int i = 0; i < N_REELS; i++) begin
            for (int j = i + 1; j < N_REELS; j++) begin
                if (reels_q[i*SYM_W +: SYM_W] == reels_q[j*SYM_W +: SYM_W]) any_pair = 1'b1;
            end
        end
        if (all_eq)        pay = JP_C;
        else if (any_pair) pay = PAIR_C;
        else               pay = '0;
    end

    // One spare bit catches the carry so the credit clamps instead of wrapping.
    assign sum_w      = {1'b0, credit_q} + {1'b0, pay};
    assign credit_sat = sum_w[CREDIT_W] ? '1 : sum_w[CREDIT_W-1:0];

    always_comb begin
        state_d   = state_q;
        credit_d  = credit_q;
        win_d     = win_q;
        pass_d    = 1'b0;
        jackpot_d = 1'b0;
        reels_d   = reels_q;
        if (clr_p) begin
            state_d  = S_IDLE;
            credit_d = INIT_C;
            win_d    = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (turn_p && !game_over) begin
                        state_d  = S_SPIN;
                        credit_d = credit_q - BET_C;
                        win_d    = '0;
                    end
                end
                S_SPIN: begin
                    if (reel_valid) begin
                        state_d = S_EVAL;
                        reels_d = reel_bus;
                    end
                end
                S_EVAL: begin
                    state_d   = S_IDLE;
                    win_d     = pay;
                    credit_d  = credit_sat;
                    pass_d    = (pay != '0);
                    jackpot_d = all_eq;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so all registers update together from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            credit_q  <= INIT_C;
            win_q     <= '0;
            pass_q    <= 1'b0;
            jackpot_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            credit_q  <= credit_d;
            win_q     <= win_d;
            pass_q    <= pass_d;
            jackpot_q <= jackpot_d;
        end
    end

    // NOTE: the reel latch is pure datapath, only read in EVAL after being loaded, so it carries no reset.
    always_ff @(posedge clk) begin
        reels_q <= reels_d;
    end

    assign credit    = credit_q;
    assign win       = win_q;
    assign pass_p    = pass_q;
    assign jackpot_p = jackpot_q;
    assign busy      = (state_q != S_IDLE);
    assign game_over = (credit_q < BET_C);

endmodule

// File: tb/tb_slot_scorer.sv
// Randomised scoreboard bench for slot_scorer: a histogram-based game model predicts
// each turn's outcome; a monitor checks it whenever busy falls.
module tb_slot_scorer;

    localparam int N      = 3;
    localparam int SW     = 4;
    localparam int CW     = 8;
    localparam int BUS_W  = N * SW;
    localparam int INIT   = 10;
    localparam int BET    = 1;
    localparam int CMAX   = (1 << CW) - 1;

    typedef struct {
        int credit;
        int win;
        bit pass;
        bit jack;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             turn_p;
    logic             clr_p;
    logic             reel_valid;
    logic [BUS_W-1:0] reel_bus;
    logic [CW-1:0]    credit, win;
    logic             pass_p, jackpot_p, busy, game_over;
    logic [CW-1:0]    sat_credit, sat_win;
    logic             sat_pass, sat_jack, sat_busy, sat_go;

    exp_t sb[$];
    int   m_credit;
    int   n_vec  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    slot_scorer u_dut (
        .clk(clk), .rst_n(rst_n), .turn_p(turn_p), .clr_p(clr_p),
        .reel_valid(reel_valid), .reel_bus(reel_bus),
        .credit(credit), .win(win), .pass_p(pass_p), .jackpot_p(jackpot_p),
        .busy(busy), .game_over(game_over)
    );

    // Second instance near the top of the credit range, for the clamp.
    slot_scorer #(.INIT_CREDIT(250)) u_sat (
        .clk(clk), .rst_n(rst_n), .turn_p(turn_p), .clr_p(clr_p),
        .reel_valid(reel_valid), .reel_bus(reel_bus),
        .credit(sat_credit), .win(sat_win), .pass_p(sat_pass), .jackpot_p(sat_jack),
        .busy(sat_busy), .game_over(sat_go)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Game rules: a symbol seen on every reel is a jackpot, one seen twice or more is a pair.
    function automatic int pay_of(input logic [BUS_W-1:0] bus, output bit jp);
        int cnt[16];
        int mx;
        mx = 0;
        foreach (cnt[s]) cnt[s] = 0;
        for (int k = 0; k < N; k++) cnt[bus[k*SW +: SW]]++;
        foreach (cnt[s]) if (cnt[s] > mx) mx = cnt[s];
        jp = (mx == N);
        if (jp)           return 10;
        else if (mx >= 2) return 2;
        else              return 0;
    endfunction

    function automatic logic [BUS_W-1:0] gen_bus(input int kind);
        logic [SW-1:0] s0, s1, s2;
        s0 = SW'($urandom);
        s1 = SW'(s0 + 4'd1 + SW'($urandom_range(0, 6)));
        s2 = SW'(s0 + 4'd8 + SW'($urandom_range(0, 6)));
        case (kind)
            0:       return {s0, s0, s0};
            1:       case ($urandom_range(0, 2))
                         0:       return {s1, s0, s0};
                         1:       return {s0, s1, s0};
                         default: return {s0, s0, s1};
                     endcase
            default: return {s2, s1, s0};
        endcase
    endfunction

    // Entered and left at a negedge; the last negedge is the DUT's completion cycle.
    task automatic do_turn(input logic [BUS_W-1:0] bus, input int spin, input bit pre_valid,
                           input bit poke, input bit abort);
        bit accepted;
        bit jp;
        int pay;
        exp_t e;
        turn_p = 1'b1;
        if (pre_valid) begin
            reel_valid = 1'b1;
            reel_bus   = bus;
        end
        accepted = (m_credit >= BET);
        @(negedge clk);
        turn_p = 1'b0;
        if (!accepted) begin
            reel_valid = 1'b0;
            check("ignored_turn_busy", 32'(busy), 32'd0);
            check("ignored_turn_credit", 32'(credit), 32'(m_credit));
            return;
        end
        m_credit -= BET;
        check("accept_busy", 32'(busy), 32'd1);
        check("accept_credit", 32'(credit), 32'(m_credit));
        if (abort) begin
            clr_p    = 1'b1;
            m_credit = INIT;
            e = '{credit: INIT, win: 0, pass: 1'b0, jack: 1'b0};
            sb.push_back(e);
            @(negedge clk);
            clr_p      = 1'b0;
            reel_valid = 1'b1;
            reel_bus   = bus;
            @(negedge clk);
            reel_valid = 1'b0;
            check("abort_late_valid_busy", 32'(busy), 32'd0);
            check("abort_credit", 32'(credit), 32'(INIT));
            return;
        end
        if (!pre_valid) begin
            repeat (spin) begin
                reel_bus = BUS_W'($urandom);
                if (poke) turn_p = 1'b1;
                @(negedge clk);
                turn_p = 1'b0;
            end
            reel_valid = 1'b1;
            reel_bus   = bus;
        end
        pay      = pay_of(bus, jp);
        m_credit = (m_credit + pay > CMAX) ? CMAX : m_credit + pay;
        e = '{credit: m_credit, win: pay, pass: (pay != 0), jack: jp};
        sb.push_back(e);
        @(negedge clk);
        reel_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_clear(input bit with_turn);
        clr_p  = 1'b1;
        turn_p = with_turn;
        @(negedge clk);
        clr_p    = 1'b0;
        turn_p   = 1'b0;
        m_credit = INIT;
        check("clear_credit", 32'(credit), 32'(INIT));
        check("clear_win", 32'(win), 32'd0);
        check("clear_busy", 32'(busy), 32'd0);
        check("clear_game_over", 32'(game_over), 32'd0);
    endtask

    // Monitor: each falling edge of busy is one finished (or abandoned) turn.
    initial begin
        logic busy_prev;
        bit   chk_pulse;
        exp_t e;
        busy_prev = 1'b0;
        chk_pulse = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (chk_pulse) begin
                    check("pass_pulse_width", 32'(pass_p), 32'd0);
                    check("jackpot_pulse_width", 32'(jackpot_p), 32'd0);
                end
                chk_pulse = 1'b0;
                if (busy_prev && !busy) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL unexpected_completion: got credit %0d expected no turn", credit);
                    end else begin
                        e = sb.pop_front();
                        check("sb_credit", 32'(credit), 32'(e.credit));
                        check("sb_win", 32'(win), 32'(e.win));
                        check("sb_pass_p", 32'(pass_p), 32'(e.pass));
                        check("sb_jackpot_p", 32'(jackpot_p), 32'(e.jack));
                        check("sb_game_over", 32'(game_over), 32'(e.credit < BET));
                        chk_pulse = 1'b1;
                    end
                end
            end
            busy_prev = busy;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        int kind;
        bit pre, abrt;
        rst_n      = 1'b0;
        turn_p     = 1'b0;
        clr_p      = 1'b0;
        reel_valid = 1'b0;
        reel_bus   = '0;
        m_credit   = INIT;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_credit", 32'(credit), 32'(INIT));
        check("reset_win", 32'(win), 32'd0);
        check("reset_pass_p", 32'(pass_p), 32'd0);
        check("reset_jackpot_p", 32'(jackpot_p), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_game_over", 32'(game_over), 32'd0);
        check("sat_reset_credit", 32'(sat_credit), 32'd250);
        check("sat_reset_busy_go", 32'({sat_busy, sat_go}), 32'd0);

        // Jackpot 7,7,7 on both instances; the high-credit one must clamp at 255.
        do_turn({4'd7, 4'd7, 4'd7}, 1, 1'b0, 1'b0, 1'b0);
        check("sat_credit_clamped", 32'(sat_credit), 32'd255);
        check("sat_win", 32'(sat_win), 32'd10);
        check("sat_pass_p", 32'(sat_pass), 32'd1);
        check("sat_jackpot_p", 32'(sat_jack), 32'd1);

        do_clear(1'b0);
        do_turn({4'd3, 4'd5, 4'd3}, 0, 1'b0, 1'b0, 1'b0);
        do_turn({4'd3, 4'd2, 4'd1}, 2, 1'b0, 1'b1, 1'b0);
        do_turn({4'd9, 4'd9, 4'd4}, 0, 1'b1, 1'b0, 1'b0);
        do_turn({4'd1, 4'd1, 4'd1}, 1, 1'b0, 1'b0, 1'b1);
        do_clear(1'b1);

        // Drain to zero with losses, then try a turn with no credit.
        repeat (INIT) do_turn(gen_bus(2), $urandom_range(0, 2), 1'b0, 1'b0, 1'b0);
        check("drain_credit", 32'(credit), 32'd0);
        check("drain_game_over", 32'(game_over), 32'd1);
        do_turn(gen_bus(0), 1, 1'b0, 1'b0, 1'b0);
        do_clear(1'b0);

        for (int t = 0; t < 200; t++) begin
            kind = $urandom_range(0, 3);
            abrt = ($urandom_range(0, 14) == 0);
            pre  = !abrt && ($urandom_range(0, 4) == 0);
            do_turn(gen_bus(kind), $urandom_range(0, 3), pre, $urandom_range(0, 1), abrt);
            if (m_credit < BET && $urandom_range(0, 1) == 1) do_clear($urandom_range(0, 1));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/slot_scorer.md
# slot_scorer

Parametrised scoring engine for the one-arm-bandit game. It generalises the fixed three-reel, 4-bit score block to N reels of configurable symbol width. Each accepted turn debits a bet, waits for the reels to stop, classifies the result as jackpot, pair or loss, and credits a saturating payout. It sits between the reel/spin controller and the display and LED driver, and adds the game-over and clear behaviour the earlier block lacked.

## Interface
- N_REELS, 3, number of reels (≥2)
- SYM_W, 4, bits per reel symbol
- CREDIT_W, 8, credit and win register width
- INIT_CREDIT, 10, credit loaded at reset and on clear (< 2^CREDIT_W)
- BET, 1, credit debited per accepted turn (≥1)
- JACKPOT_PAY, 10, payout when all reels are equal
- PAIR_PAY, 2, payout when at least two reels match but not all

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- turn_p  in  1  one-cycle start-turn pulse
- clr_p  in  1  one-cycle new-game pulse
- reel_valid  in  1  reels stopped and reel_bus stable
- reel_bus  in  N_REELS*SYM_W  reel k occupies bits [k*SYM_W +: SYM_W]
- credit  out  CREDIT_W  current credit (registered)
- win  out  CREDIT_W  payout of the last evaluated turn (registered)
- pass_p  out  1  one-cycle pulse when win > 0
- jackpot_p  out  1  one-cycle pulse on a jackpot
- busy  out  1  high in SPIN or EVAL
- game_over  out  1  credit < BET (combinational from credit)

## Operation
- Reset values: state IDLE, credit = INIT_CREDIT, win = 0, pass_p = jackpot_p = 0, busy = 0.
- Priority at each edge: rst_n, then clr_p, then normal FSM operation.
- clr_p in any state:
  - state → IDLE, credit ← INIT_CREDIT, win ← 0, pulses ← 0.
  - Any in-flight turn is abandoned with no payout.
- FSM states: IDLE, SPIN, EVAL.
- IDLE → SPIN when turn_p = 1 and credit ≥ BET.
  - credit ← credit − BET at that edge.
  - win ← 0 at that edge.
- turn_p is ignored in SPIN or EVAL, and in IDLE when credit < BET. Ignored means no debit and no state change.
- SPIN → EVAL at the first edge with reel_valid = 1. reel_bus is latched into an internal register at that edge.
  - reel_valid is ignored outside SPIN.
- Classification of the latched reels:
  - Jackpot: all N_REELS symbols are equal.
  - Pair: any two reels i ≠ j are equal, and the result is not a jackpot.
  - Otherwise: loss, pay = 0.
- EVAL → IDLE at the next edge. At that edge:
  - win ← pay
  - credit ← min(credit + pay, 2^CREDIT_W − 1), saturating and never wrapping
  - pass_p ← (pay ≠ 0)
  - jackpot_p ← jackpot
- pass_p and jackpot_p clear at the following edge unless a new EVAL completes.
- win holds its value until the next accepted turn, a clear, or a reset.
- Arithmetic: the add is computed at CREDIT_W+1 bits, then clamped. The debit cannot underflow because of the credit ≥ BET guard.

## Timing
- Turn accepted at edge T0: busy = 1 and the debited credit are visible after T0.
- reel_valid sampled high at edge T1: state = EVAL after T1.
- Edge T1+1: credit, win, pass_p and jackpot_p update, busy = 0. Latency from reel_valid to payout is 2 edges.
- pass_p is high for exactly the cycle between edges T1+1 and T1+2.
- A turn_p during that pulse cycle is accepted. Its debit and pass_p dropping occur at the same edge.
- reel_valid already high when SPIN is entered: EVAL follows at the very next edge (minimum T1 = T0+1).
- clr_p and turn_p in the same cycle: clear wins and the turn is not accepted.

## Test plan
All scenarios use default parameters unless stated.
- Reset held 2 cycles, then released → credit = 10, win = 0, pass_p = jackpot_p = busy = game_over = 0.
- Jackpot: turn_p, then reel_valid with reels 7,7,7 → credit 9 after accept; 2 edges after reel_valid, credit = 19, win = 10, pass_p = jackpot_p = 1 for one cycle.
- Pair and loss:
  - Reels 3,5,3 → credit 9 → 11, win = 2, pass_p = 1, jackpot_p = 0.
  - Reels 1,2,3 → credit 10 → 9, win = 0, no pulses.
- Drain: ten loss turns from credit 10 → credit = 0, game_over = 1; a further turn_p leaves busy = 0 and credit = 0; then clr_p → credit = 10, game_over = 0.
- Ignored and abort:
  - turn_p pulsed during SPIN → no extra debit.
  - clr_p during SPIN → IDLE, credit = 10; a later reel_valid has no effect.
- Saturation with INIT_CREDIT = 250: jackpot turn → credit 249 → 255 (not 259 mod 256), win = 10, pass_p = 1.
